// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared definitions for the convolution result writer:
//               default data/address widths, layer-memory select codes and
//               the writer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    // 4-bit signed integer part plus 16-bit fraction
    localparam int DATAW = 20;
    // 64x64 image, row-major {y[5:0], x[5:0]}
    localparam int ADDRW = 12;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_K0  = 2'd1,
        ST_WR_K1  = 2'd2,
        ST_FINISH = 2'd3
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/result_skid_buf.sv
// ============================================================================
// Module      : result_skid_buf
// Description : One-entry pending buffer for a kernel-0/kernel-1 result pair.
//               A push into a full buffer drops the new pair and sets a
//               sticky overflow flag that only reset clears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_skid_buf #(
    parameter int DATAW = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] din_k0,
    input  logic [DATAW-1:0] din_k1,
    output logic             valid,
    output logic [DATAW-1:0] dout_k0,
    output logic [DATAW-1:0] dout_k1,
    output logic             overflow
);

    // Hold one pair; a push while occupied (even while draining) is dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            dout_k0  <= '0;
            dout_k1  <= '0;
        end else begin
            if (pop) begin
                valid <= 1'b0;
            end
            if (push) begin
                if (valid) begin
                    overflow <= 1'b1;
                end else begin
                    valid   <= 1'b1;
                    dout_k0 <= din_k0;
                    dout_k1 <= din_k1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_result_writer.sv
// ============================================================================
// Module      : conv_result_writer
// Description : Writes each kernel-0/kernel-1 convolution result pair into
//               layer-0 memory as two consecutive write cycles at the current
//               pixel address, with a one-entry pending buffer for strobes
//               that arrive while a pair is still being written.
//               Build option: WRITER_RELU_EN applies ReLU at the write port
//               (negative values are written as zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_writer #(
    parameter int DATAW = conv_pkg::DATAW,
    parameter int ADDRW = conv_pkg::ADDRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             done,
    input  logic [DATAW-1:0] resultK0,
    input  logic [DATAW-1:0] resultK1,
    output logic             ready,
    output logic             cwr,
    output logic [2:0]       csel,
    output logic [ADDRW-1:0] caddr_wr,
    output logic [DATAW-1:0] cdata_wr,
    output logic             frame_done,
    output logic             overflow
);

    import conv_pkg::*;

    wr_state_t        state, state_nxt;
    logic [ADDRW-1:0] pix_cnt;
    logic [DATAW-1:0] cur_k0, cur_k1;
    logic [DATAW-1:0] pend_k0, pend_k1;
    logic [DATAW-1:0] wr_data;
    logic             pend_valid;
    logic             sampled;
    logic             last_pix;
    logic             take_new;
    logic             pop;
    logic             push;

    assign sampled  = done && en;
    assign last_pix = (pix_cnt == {ADDRW{1'b1}});
    // Any strobe not loaded straight into the write registers goes to the buffer
    assign push     = sampled && !take_new;
    assign ready    = !pend_valid;

    result_skid_buf #(
        .DATAW (DATAW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din_k0   (resultK0),
        .din_k1   (resultK1),
        .valid    (pend_valid),
        .dout_k0  (pend_k0),
        .dout_k1  (pend_k1),
        .overflow (overflow)
    );

    // State register, pixel counter and the pair currently being written
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pix_cnt <= '0;
            cur_k0  <= '0;
            cur_k1  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WR_K1) begin
                pix_cnt <= pix_cnt + ADDRW'(1);
            end
            if (take_new) begin
                cur_k0 <= resultK0;
                cur_k1 <= resultK1;
            end else if (pop) begin
                cur_k0 <= pend_k0;
                cur_k1 <= pend_k1;
            end
        end
    end

    // Next-state selection; a buffered pair has priority over a fresh strobe,
    // and a fresh strobe with an empty buffer is written back-to-back
    always_comb begin
        state_nxt = state;
        take_new  = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sampled) begin
                    take_new  = 1'b1;
                    state_nxt = ST_WR_K0;
                end
            end
            ST_WR_K0: begin
                state_nxt = ST_WR_K1;
            end
            ST_WR_K1: begin
                if (last_pix) begin
                    state_nxt = ST_FINISH;
                end else if (pend_valid) begin
                    pop       = 1'b1;
                    state_nxt = ST_WR_K0;
                end else if (sampled) begin
                    take_new  = 1'b1;
                    state_nxt = ST_WR_K0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FINISH: begin
                if (pend_valid) begin
                    pop       = 1'b1;
                    state_nxt = ST_WR_K0;
                end else if (sampled) begin
                    take_new  = 1'b1;
                    state_nxt = ST_WR_K0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write-port data, optionally clamped to zero for negative values
    always_comb begin
        wr_data = (state == ST_WR_K0) ? cur_k0 : cur_k1;
`ifdef WRITER_RELU_EN
        if (wr_data[DATAW-1]) begin
            wr_data = '0;
        end
`endif
    end

    // Memory-port outputs decoded from the current state
    always_comb begin
        cwr        = 1'b0;
        csel       = CSEL_NONE;
        caddr_wr   = '0;
        cdata_wr   = '0;
        frame_done = 1'b0;
        case (state)
            ST_WR_K0: begin
                cwr      = 1'b1;
                csel     = CSEL_L0K0;
                caddr_wr = pix_cnt;
                cdata_wr = wr_data;
            end
            ST_WR_K1: begin
                cwr      = 1'b1;
                csel     = CSEL_L0K1;
                caddr_wr = pix_cnt;
                cdata_wr = wr_data;
            end
            ST_FINISH: begin
                frame_done = 1'b1;
            end
            default: begin
                cwr = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Self-checking bench for conv_result_writer. Each accepted
//               result pair is scheduled on a timeline (start = later of its
//               capture edge and the end of the previous pair) and the
//               expected port values for every cycle are derived from that
//               schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_writer;

    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          done;
    logic [DW-1:0] resultK0;
    logic [DW-1:0] resultK1;
    logic          ready;
    logic          cwr;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          frame_done;
    logic          overflow;

    always #5 clk = ~clk;

    conv_result_writer #(.DATAW(DW), .ADDRW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .done       (done),
        .resultK0   (resultK0),
        .resultK1   (resultK1),
        .ready      (ready),
        .cwr        (cwr),
        .csel       (csel),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        int          cap;
        int          start;
        int          endt;
        int          addr;
        logic [DW-1:0] k0;
        logic [DW-1:0] k1;
    } pair_t;

    pair_t q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    t          = 0;
    int    last_end   = 0;
    int    pix        = 0;
    bit    ovf_m      = 1'b0;

    function automatic logic [DW-1:0] port_val(input logic [DW-1:0] d);
`ifdef WRITER_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, t, obs, expv);
        end
    endtask

    // Apply the acceptance rules at rising edge t
    task automatic model_edge();
        bit    full;
        pair_t p;
        full = 1'b0;
        if (!reset) begin
            q.delete();
            last_end = t;
            pix      = 0;
            ovf_m    = 1'b0;
        end else if (done && en) begin
            foreach (q[i]) begin
                if (q[i].cap < t && q[i].start >= t && q[i].start > q[i].cap) full = 1'b1;
            end
            if (full) begin
                ovf_m = 1'b1;
            end else begin
                p.cap   = t;
                p.start = (t > last_end) ? t : last_end;
                p.addr  = pix;
                p.endt  = p.start + 2 + ((pix == 4095) ? 1 : 0);
                p.k0    = resultK0;
                p.k1    = resultK1;
                q.push_back(p);
                last_end = p.endt;
                pix      = (pix + 1) % 4096;
            end
        end
    endtask

    // Compare every output against the schedule for the cycle after edge t
    task automatic check_outputs();
        logic          e_cwr;
        logic [2:0]    e_csel;
        int            e_addr;
        logic [DW-1:0] e_data;
        logic          e_fd;
        logic          e_rdy;
        int            ph;
        e_cwr  = 1'b0;
        e_csel = 3'b000;
        e_addr = 0;
        e_data = '0;
        e_fd   = 1'b0;
        e_rdy  = 1'b1;
        while (q.size() > 0 && q[0].endt <= t) void'(q.pop_front());
        if (q.size() > 0 && q[0].start <= t) begin
            ph = t - q[0].start;
            if (ph == 0) begin
                e_cwr = 1'b1; e_csel = 3'b001; e_addr = q[0].addr; e_data = port_val(q[0].k0);
            end else if (ph == 1) begin
                e_cwr = 1'b1; e_csel = 3'b010; e_addr = q[0].addr; e_data = port_val(q[0].k1);
            end else begin
                e_fd = 1'b1;
            end
        end
        foreach (q[i]) begin
            if (q[i].cap <= t && t < q[i].start) e_rdy = 1'b0;
        end
        chk("cwr",        32'(cwr),        32'(e_cwr));
        chk("csel",       32'(csel),       32'(e_csel));
        chk("caddr_wr",   32'(caddr_wr),   32'(e_addr));
        chk("cdata_wr",   32'(cdata_wr),   32'(e_data));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("ready",      32'(ready),      32'(e_rdy));
        chk("overflow",   32'(overflow),   32'(ovf_m));
    endtask

    task automatic step(input logic rs, input logic d, input logic e,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        reset    = rs;
        done     = d;
        en       = e;
        resultK0 = a;
        resultK1 = b;
        @(posedge clk);
        t++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom()), DW'($urandom()));
    endtask

    task automatic strobe();
        step(1'b1, 1'b1, 1'b1, DW'($urandom()), DW'($urandom()));
    endtask

    initial begin
        reset = 1'b0; done = 1'b0; en = 1'b0; resultK0 = '0; resultK1 = '0;

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);

        // Single pair at pixel 0 with fixed values
        step(1'b1, 1'b1, 1'b1, 20'h0A89E, 20'hFDB55);
        idle(4);

        // Negative kernel-0 value, positive kernel-1 value
        step(1'b1, 1'b1, 1'b1, 20'hF8F71, 20'h02992);
        idle(4);

        // Strobe in WR_K1 (bypass) then strobe in following WR_K0 (buffered)
        strobe();
        idle(1);
        strobe();
        strobe();
        idle(6);

        // en drops mid-pair: current pair completes, new strobes ignored
        strobe();
        step(1'b1, 1'b1, 1'b0, DW'($urandom()), DW'($urandom()));
        step(1'b1, 1'b1, 1'b0, DW'($urandom()), DW'($urandom()));
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Three consecutive strobes: third dropped, overflow sticks
        step(1'b0, 1'b0, 1'b1, '0, '0);
        idle(1);
        strobe();
        strobe();
        strobe();
        idle(8);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0),
                 DW'($urandom()), DW'($urandom()));
        end
        idle(4);

        // Reset during WR_K0 abandons the pair; next write goes to address 0
        strobe();
        idle(3);
        strobe();
        step(1'b0, 1'b0, 1'b1, DW'($urandom()), DW'($urandom()));
        idle(1);
        strobe();
        idle(3);

        // Full frame: 4096 strobes ten cycles apart, counter wraps to 0
        step(1'b0, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 4096; i++) begin
            strobe();
            idle(9);
        end
        strobe();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
